// File: rtl/fb_reader_pkg.sv
// Shared types for the framebuffer reader: FSM encoding and the FIFO pixel word.
package fb_reader_pkg;

    typedef enum logic [1:0] {IDLE, BURST, GAP} fsm_t;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } pix_word_t;

    // Counter width that stays legal for a range of one.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Show-ahead FIFO: the head entry is visible on dout whenever empty is low.
module fb_fifo
    import fb_reader_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = 34
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [cw(DEPTH):0]     free
);

    localparam int AW = cw(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign free    = CW'(DEPTH) - count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fb_reader.sv
// Wishbone read master streaming a raster-order framebuffer into a tagged pixel stream.
module fb_reader
    import fb_reader_pkg::*;
#(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_done
);

    localparam int PW = cw(HDISP);
    localparam int LW = cw(VDISP);
    localparam int BW = cw(BURST_LEN);
    localparam int FW = cw(FIFO_DEPTH) + 1;

    fsm_t          state_q, state_d;
    logic [PW-1:0] pixel_cpt_q, pixel_cpt_d;
    logic [LW-1:0] line_cpt_q, line_cpt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          frame_end_q, frame_end_d;
    logic          frame_done_q;

    logic          ack_take, at_origin, line_end, last_pix, room;
    logic          fifo_full, fifo_empty, pop;
    logic [FW-1:0] fifo_free;
    pix_word_t     push_word, head;

    assign wb_cyc = (state_q == BURST);
    assign wb_stb = (state_q == BURST);
    assign wb_we  = 1'b0;
    assign wb_sel = 4'hF;
    assign wb_cti = 3'b000;
    assign wb_bte = 2'b00;
    assign wb_adr = BASE_ADR + ((32'(line_cpt_q) * 32'(HDISP)) + 32'(pixel_cpt_q)) * 32'd4;

    assign ack_take  = (state_q == BURST) && wb_ack;
    assign at_origin = (pixel_cpt_q == '0) && (line_cpt_q == '0);
    assign line_end  = (pixel_cpt_q == PW'(HDISP - 1));
    assign last_pix  = line_end && (line_cpt_q == LW'(VDISP - 1));
    assign room      = (fifo_free >= FW'(BURST_LEN));

    assign push_word = '{sof: at_origin, eol: line_end, data: wb_dat_sm};

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        pixel_cpt_d = pixel_cpt_q;
        line_cpt_d  = line_cpt_q;
        burst_d     = burst_q;
        frame_end_d = frame_end_q;
        case (state_q)
            IDLE: begin
                if (enable && at_origin && room) begin
                    state_d = BURST;
                    burst_d = '0;
                end
            end
            BURST: begin
                if (wb_ack) begin
                    burst_d = burst_q + BW'(1);
                    if (line_end) begin
                        pixel_cpt_d = '0;
                        line_cpt_d  = last_pix ? '0 : line_cpt_q + LW'(1);
                    end else begin
                        pixel_cpt_d = pixel_cpt_q + PW'(1);
                    end
                    if (last_pix) frame_end_d = 1'b1;
                    if (last_pix || burst_q == BW'(BURST_LEN - 1)) state_d = GAP;
                end
            end
            GAP: begin
                // enable is only honoured here once the whole frame has been fetched.
                if (frame_end_q && !enable) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b0;
                end else if (room) begin
                    state_d     = BURST;
                    burst_d     = '0;
                    frame_end_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pixel_cpt_q  <= '0;
            line_cpt_q   <= '0;
            burst_q      <= '0;
            frame_end_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pixel_cpt_q  <= pixel_cpt_d;
            line_cpt_q   <= line_cpt_d;
            burst_q      <= burst_d;
            frame_end_q  <= frame_end_d;
            frame_done_q <= ack_take && last_pix;
        end
    end

    assign frame_done = frame_done_q;

    fb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_word_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ack_take),
        .din   (push_word),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;
    assign pix_data  = pix_valid ? head.data : '0;
    assign pix_sof   = pix_valid && head.sof;
    assign pix_eol   = pix_valid && head.eol;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(ack_take && fifo_full));

endmodule

// File: doc/fb_reader.md
Name: fb_reader

Overview:
- Wishbone master that reads a HDISP x VDISP framebuffer of 32-bit pixels, in raster order, from the shared video SDRAM.
- It is the read-side counterpart of the pattern and framebuffer writers.
- Read data is pushed into an internal FIFO and presented to the display pipeline as a valid/ready pixel stream, tagged with start-of-frame and end-of-line flags.

Parameters:
- HDISP, 800, pixels per line
- VDISP, 480, lines per frame
- BASE_ADR, 32'h0, byte address of pixel (0,0)
- BURST_LEN, 64, reads per bus tenure (cyc high); power of two, at most FIFO_DEPTH
- FIFO_DEPTH, 128, pixel FIFO entries; power of two

Ports:
- clk  in  1  system clock, shared with the Wishbone bus
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; sampled only at frame boundaries
- wb_cyc  out  1  bus cycle
- wb_stb  out  1  strobe
- wb_we  out  1  constant 0
- wb_adr  out  32  byte address
- wb_sel  out  4  constant 4'b1111
- wb_cti  out  3  constant 3'b000
- wb_bte  out  2  constant 2'b00
- wb_dat_sm  in  32  read data
- wb_ack  in  1  transfer acknowledge
- pix_data  out  32  pixel value
- pix_sof  out  1  pixel (0,0) of a frame
- pix_eol  out  1  last pixel of a line
- pix_valid  out  1  stream valid
- pix_ready  in  1  stream ready
- frame_done  out  1  one-cycle pulse when the ack for pixel (HDISP-1,VDISP-1) is taken

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; pixel_cpt=0, line_cpt=0; FIFO empty.
- All outputs are 0 at reset except the constants wb_we=0 and wb_sel=4'hF.
- Counters:
  - pixel_cpt is $clog2(HDISP) bits; line_cpt is $clog2(VDISP) bits.
  - Both advance only on wb_ack.
  - pixel_cpt wraps at HDISP-1 and increments line_cpt.
  - line_cpt wraps at VDISP-1 back to 0, marking the frame end.
- Address: wb_adr = BASE_ADR + (line_cpt*HDISP + pixel_cpt)*4, computed in 32 bits and combinational from the counters.
- Classic Wishbone handshake: one transfer outstanding; wb_stb and wb_adr are held stable until wb_ack; wb_stb is never withdrawn before wb_ack.
- FSM states: IDLE, BURST, GAP.
  - IDLE -> BURST when enable=1, the counters are at (0,0), and FIFO free space >= BURST_LEN. In BURST: wb_cyc=wb_stb=1, and a burst counter resets to 0.
  - BURST: each wb_ack writes {sof,eol,wb_dat_sm} into the FIFO and increments the burst counter.
    - When the ack completes beat BURST_LEN-1, or completes the last pixel of the frame, go to GAP with cyc=stb=0 from the next cycle.
  - GAP lasts at least 1 cycle with cyc low, releasing the bus to the arbiter. Exit:
    - frame end and enable=0 -> IDLE;
    - otherwise -> BURST once free space >= BURST_LEN.
- Because the free-space check is made before each burst, a FIFO write can never hit full. An ack arriving while the FIFO is full is a design error and is flagged by an assertion.
- Bursts may cross line boundaries. The last burst of a frame is shortened when HDISP*VDISP is not a multiple of BURST_LEN.
- Flags: sof=1 when (pixel_cpt,line_cpt)=(0,0) at the ack; eol=1 when pixel_cpt=HDISP-1 at the ack.
- Stream output:
  - The FIFO head drives pix_data/sof/eol; pix_valid = FIFO not empty.
  - A pop occurs on pix_valid & pix_ready. The head data is held stable while valid and not ready.
- Latency: ack to pix_valid is 1 cycle (registered FIFO write, FIFO read is show-ahead).
- A simultaneous push and pop leaves the occupancy unchanged; push and pop are both legal when the FIFO is full.
- enable dropped mid-frame: the current frame completes. The block then returns to IDLE after its final GAP.
- frame_done is asserted in the cycle after the final ack.
- The FIFO is never flushed except by reset.

Decomposition:
- Package fb_reader_pkg:
  - typedef fsm_t {IDLE, BURST, GAP};
  - typedef pix_word_t, a packed struct {sof, eol, data[31:0]} (34 bits).
- Sub-module fb_fifo:
  - parameters DEPTH and WIDTH;
  - show-ahead FIFO exposing full, empty and a free-space count;
  - asynchronous active-low reset.

Test Plan:
- HDISP=8, VDISP=4, BURST_LEN=4, slave acks every cycle, pix_ready=1 -> wb_adr sequence is 0,4,...,124.
  - cyc drops for >=1 cycle after every 4 acks.
  - 32 pixels come out in order; sof only on pixel 0; eol on pixels 7,15,23,31.
  - frame_done pulses once.
- Slave inserts 0-3 random wait states -> wb_stb and wb_adr remain stable until each ack; pixel data order is unchanged.
- pix_ready=0 with FIFO_DEPTH=8, BURST_LEN=4 -> exactly 8 acks, then cyc stays low. Raise pix_ready -> bursts resume once 4 entries are free.
- enable deasserted at pixel 10 of frame 1 -> frame 1 completes (32 acks). The FSM goes to IDLE and no further wb_cyc occurs. Re-enabling restarts at adr=BASE_ADR with sof=1.
- rst_n asserted mid-burst -> wb_cyc and wb_stb go 0 immediately; pix_valid=0. After release, reads restart at address BASE_ADR.
- HDISP*VDISP=30, BURST_LEN=4 -> the last burst has 2 acks, then GAP and wrap to (0,0).
